// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: arctan table, the
// 1/K gain fraction, mode encoding and the controller state type.
package cordic_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  // 0.6072529350 (inverse CORDIC gain) as an unsigned 0.32 fraction.
  localparam logic [31:0] KN_FRAC = 32'h9B74_EDA8;

  localparam int ATAN_ENTRIES = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

  // atan(2^-i) in turns, scaled to 2^32 (full circle = 2^32).
  function automatic logic [31:0] atan32(input int i);
    case (i)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      16:      return 32'h0000_28BE;
      17:      return 32'h0000_145F;
      18:      return 32'h0000_0A30;
      19:      return 32'h0000_0518;
      20:      return 32'h0000_028C;
      21:      return 32'h0000_0146;
      22:      return 32'h0000_00A3;
      23:      return 32'h0000_0051;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Arctan entry reduced to a w-bit angle (2^w = 360 deg), rounded.
  function automatic logic [31:0] atan_scaled(input int i, input int w);
    logic [31:0] half;
    half = 32'd1 << (31 - w);
    return (atan32(i) + half) >> (32 - w);
  endfunction

  // Initial x for rotation mode: 1/K with 1.0 = 2^(w-2), rounded.
  function automatic logic [31:0] kn_scaled(input int w);
    logic [31:0] half;
    half = 32'd1 << (33 - w);
    return (KN_FRAC + half) >> (34 - w);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation, shared by rotation and
// vectoring modes. dir_i = 1 selects d = +1, dir_i = 0 selects d = -1.
module cordic_stage #(
  parameter int DW    = 18,
  parameter int CNT_W = 5
) (
  input  logic signed [DW-1:0]    x_i,
  input  logic signed [DW-1:0]    y_i,
  input  logic signed [DW-1:0]    z_i,
  input  logic        [CNT_W-1:0] shift_i,
  input  logic                    dir_i,
  input  logic signed [DW-1:0]    atan_i,
  output logic signed [DW-1:0]    x_o,
  output logic signed [DW-1:0]    y_o,
  output logic signed [DW-1:0]    z_o
);

  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;

  // Arithmetic shifts truncate toward -inf; no rounding is applied.
  always_comb begin
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    if (dir_i) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, sin/cos in
// rotation mode, magnitude/atan2 in vectoring mode.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE and out_valid only in DONE, so the engine holds at most
// one operation and requests presented while busy are simply not taken.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 14
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic        [WIDTH-1:0] in_theta,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic        [WIDTH-1:0] out_z,
  output logic                    busy,
  output cordic_state_e           dbg_state_o
);

  if (WIDTH < 8 || WIDTH > ATAN_ENTRIES || ITERS < 1 || ITERS > WIDTH) begin : g_param_check
    $error("cordic_iter_engine: illegal WIDTH=%0d / ITERS=%0d", WIDTH, ITERS);
  end

  // Two headroom bits above the WIDTH-bit result format.
  localparam int DW    = WIDTH + 2;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0]     LAST_ITER    = CNT_W'(ITERS - 1);
  localparam logic [31:0]          KN32         = kn_scaled(WIDTH);
  localparam logic signed [DW-1:0] KN           = {2'b00, KN32[WIDTH-1:0]};
  localparam logic signed [DW-1:0] HALF_TURN    = {3'b001, {(WIDTH-1){1'b0}}};
  localparam logic signed [DW-1:0] QUARTER_TURN = {4'b0001, {(WIDTH-2){1'b0}}};
  localparam logic signed [DW-1:0] SAT_MAX      = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN      = {3'b111, {(WIDTH-1){1'b0}}};

  cordic_state_e state_q, state_d;

  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [DW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic                    mode_q, mode_d;
  logic                    neg_q, neg_d;
  logic                    zero_q, zero_d;
  logic signed [WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic        [WIDTH-1:0] out_z_q, out_z_d;

  logic signed [DW-1:0]    x_init, y_init, z_init;
  logic                    neg_init, zero_init;
  logic signed [DW-1:0]    x_ext, y_ext, theta_ext;
  logic        [WIDTH-1:0] theta_fold;

  logic                    dir;
  logic signed [DW-1:0]    x_n, y_n, z_n;
  logic signed [DW-1:0]    x_fin, y_fin;

  // Arctan table, one WIDTH-bit angle per iteration, zero-padded to 32 entries.
  logic signed [DW-1:0] atan_tab [32];
  for (genvar g = 0; g < 32; g++) begin : g_atan
    localparam logic [31:0] ATAN_G = atan_scaled(g, WIDTH);
    assign atan_tab[g] = ATAN_G[DW-1:0];
  end

  function automatic logic [WIDTH-1:0] saturate(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  // Initial vector/angle for a new request, including quadrant folding.
  always_comb begin
    x_init     = '0;
    y_init     = '0;
    z_init     = '0;
    neg_init   = 1'b0;
    zero_init  = 1'b0;
    x_ext      = {{2{in_x[WIDTH-1]}}, in_x};
    y_ext      = {{2{in_y[WIDTH-1]}}, in_y};
    theta_ext  = {{2{in_theta[WIDTH-1]}}, in_theta};
    // Adding 180 deg modulo 2^WIDTH is a flip of the angle MSB.
    theta_fold = {~in_theta[WIDTH-1], in_theta[WIDTH-2:0]};
    if (in_mode == MODE_VECTOR) begin
      zero_init = (in_x == '0) && (in_y == '0);
      if (in_x[WIDTH-1]) begin
        x_init = -x_ext;
        y_init = -y_ext;
        z_init = HALF_TURN;
      end else begin
        x_init = x_ext;
        y_init = y_ext;
      end
    end else begin
      x_init = KN;
      if (theta_ext > QUARTER_TURN || theta_ext < -QUARTER_TURN) begin
        neg_init = 1'b1;
        z_init   = {{2{theta_fold[WIDTH-1]}}, theta_fold};
      end else begin
        z_init   = theta_ext;
      end
    end
  end

  // Rotation drives z toward zero, vectoring drives y toward zero.
  always_comb begin
    if (mode_q == MODE_VECTOR) dir = y_q[DW-1];
    else                       dir = ~z_q[DW-1];
  end

  cordic_stage #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .dir_i   (dir),
    .atan_i  (atan_tab[cnt_q]),
    .x_o     (x_n),
    .y_o     (y_n),
    .z_o     (z_n)
  );

  // Undo the 180 deg fold on the final rotation result.
  always_comb begin
    x_fin = neg_q ? -x_n : x_n;
    y_fin = neg_q ? -y_n : y_n;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)            state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_ITER)  state_d = ST_DONE;
      ST_DONE: if (out_ready)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // Datapath next-state: capture on accept, iterate in RUN, publish at the end.
  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    out_z_d = out_z_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d    = x_init;
          y_d    = y_init;
          z_d    = z_init;
          mode_d = in_mode;
          neg_d  = neg_init;
          zero_d = zero_init;
          cnt_d  = '0;
        end
      end
      ST_RUN: begin
        x_d   = x_n;
        y_d   = y_n;
        z_d   = z_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          out_x_d = saturate(x_fin);
          out_y_d = saturate(y_fin);
          // A zero vector has no defined angle; report 0 instead of the
          // accumulated sum of arctan steps.
          out_z_d = zero_q ? '0 : z_n[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
      out_z_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      out_z_q <= out_z_d;
    end
  end

  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_z       = out_z_q;
  assign dbg_state_o = state_q;

endmodule
